uart_cmd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART command engine (`uart_fsm`) among `NUM_REQ` independent requesters. It accepts one command at a time, drives the engine's valid/ready command port, and tracks the transaction until the engine returns to idle. It then routes the completion, and read data if any, back to the requester that issued it. It sits between the register-access clients and `uart_fsm`, and is clocked and reset with it.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_cmd_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_cmd_arbiter.sv | 112 +++++++++++
 tb/tb_uart_cmd_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART command arbiter: FSM encoding, widths, R/W flag location.
// No logic here; latency/backpressure live in the modules that import it.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_CMD_WIDTH      = 16;
  localparam int DEF_CMD_DATA_WIDTH = 8;

  // The R/W flag is the command MSB: 1 = write, 0 = read.
  localparam int RW_FLAG_POS = DEF_CMD_WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DROP = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_e;

  function automatic int rw_flag_pos(input int cmd_width);
    return cmd_width - 1;
  endfunction

endpackage

// File: rtl/uart_cmd_arbiter_if.sv
// Bundles requester-side and engine-side signals of the arbiter.
// slave = arbiter view, master = environment (requesters + engine) view.
interface uart_cmd_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int CMD_WIDTH      = DEF_CMD_WIDTH,
  parameter int CMD_DATA_WIDTH = DEF_CMD_DATA_WIDTH,
  parameter int IDX_W          = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [CMD_DATA_WIDTH-1:0]    rsp_data;
  logic                         rsp_err;
  logic                         uart_cmd_valid;
  logic [CMD_WIDTH-1:0]         uart_cmd_data;
  logic                         uart_cmd_ready;
  logic                         uart_read_valid;
  logic [CMD_DATA_WIDTH-1:0]    uart_read_data;
  logic [IDX_W-1:0]             owner;
  logic                         busy;

  modport slave (
    input  req_valid, req_data, uart_cmd_ready, uart_read_valid, uart_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, uart_cmd_valid, uart_cmd_data,
           owner, busy
  );

  modport master (
    output req_valid, req_data, uart_cmd_ready, uart_read_valid, uart_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, uart_cmd_valid, uart_cmd_data,
           owner, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
// Zero latency; no state, so no backpressure of its own.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    // k is the distance from ptr; the first hit in distance order wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
          w_found = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Shares one UART command engine among NUM_REQ requesters, one command in flight at a time.
// Grant -> engine valid 1 cycle; response 1 cycle after engine ready returns; requesters wait via req_ready.
module uart_cmd_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int CMD_WIDTH      = DEF_CMD_WIDTH,
  parameter int CMD_DATA_WIDTH = DEF_CMD_DATA_WIDTH,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_cmd_arbiter_if.slave bus
);

  localparam int RW_BIT = rw_flag_pos(CMD_WIDTH);

  arb_state_e                r_state;
  arb_state_e                w_state_nxt;
  logic [CMD_WIDTH-1:0]      r_cmd_q;
  logic [CMD_DATA_WIDTH-1:0] r_rd_q;
  logic                      r_rd_got;
  logic [IDX_W-1:0]          r_owner;
  logic [IDX_W-1:0]          r_rr_ptr;

  logic [NUM_REQ-1:0]        w_gnt;
  logic [IDX_W-1:0]          w_gnt_idx;
  logic [IDX_W-1:0]          w_ptr_nxt;
  logic [CMD_WIDTH-1:0]      w_sel_cmd;
  logic                      w_grant;
  logic                      w_is_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_cmd = bus.req_data[i*CMD_WIDTH +: CMD_WIDTH];
    end
  end

  // rst_n gating keeps req_ready at its reset value while reset is held.
  assign w_grant    = rst_n && (r_state == ST_IDLE) && (|w_gnt);
  assign w_ptr_nxt  = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
  assign w_is_write = r_cmd_q[RW_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (|bus.req_valid)      w_state_nxt = ST_ISSUE;
      ST_ISSUE:     if (bus.uart_cmd_ready)  w_state_nxt = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!bus.uart_cmd_ready) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.uart_cmd_ready)  w_state_nxt = ST_RESP;
      ST_RESP:                               w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_q  <= '0;
      r_rd_q   <= '0;
      r_rd_got <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_grant) begin
        r_cmd_q  <= w_sel_cmd;
        r_owner  <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
        r_rd_got <= 1'b0;
      end
      if ((r_state == ST_WAIT_DONE) && bus.uart_read_valid) begin
        r_rd_q   <= bus.uart_read_data;
        r_rd_got <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = w_grant ? w_gnt : '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = (r_state == ST_RESP) && (r_owner == IDX_W'(i));
    end
    bus.rsp_data       = '0;
    bus.rsp_err        = 1'b0;
    // A read with no captured data means the engine dropped it on parity.
    if ((r_state == ST_RESP) && !w_is_write) begin
      bus.rsp_data = r_rd_q;
      bus.rsp_err  = ~r_rd_got;
    end
    bus.uart_cmd_valid = (r_state == ST_ISSUE);
    bus.uart_cmd_data  = r_cmd_q;
    bus.owner          = r_owner;
    bus.busy           = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Scoreboarded bench: requester queues and an engine model drive the arbiter; a monitor checks grants and responses.
module tb_uart_cmd_arbiter;
  import uart_arb_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 16;
  localparam int DW   = 8;
  localparam int BUSY = 20;

  typedef struct {
    int          idx;
    logic [15:0] cmd;
  } gnt_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
    logic       chk_data;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_arbiter_if #(.NUM_REQ(N), .CMD_WIDTH(CW), .CMD_DATA_WIDTH(DW)) bus ();

  uart_cmd_arbiter #(.NUM_REQ(N), .CMD_WIDTH(CW), .CMD_DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  gnt_t exp_gnt_q[$];
  rsp_t exp_rsp_q[$];

  // Requester side
  logic [15:0]     rq_cmd [N][8];
  int              rq_head [N];
  int              rq_cnt  [N];
  logic [N-1:0]    req_v = '0;
  logic [N*CW-1:0] req_d = '0;
  logic [N-1:0]    drv_acc;

  assign bus.req_valid = req_v;
  assign bus.req_data  = req_d;

  // Engine model
  logic       eng_ready   = 1'b1;
  logic       eng_rv      = 1'b0;
  logic [7:0] eng_rd      = 8'h00;
  logic [7:0] eng_rdata   = 8'h00;
  logic       eng_pfail   = 1'b0;
  logic       eng_rv_late = 1'b0;
  logic       eng_pend    = 1'b0;
  logic       eng_is_read = 1'b0;
  int         eng_cnt     = 0;

  assign bus.uart_cmd_ready  = eng_ready;
  assign bus.uart_read_valid = eng_rv;
  assign bus.uart_read_data  = eng_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int i, input logic [15:0] cmd);
    rq_cmd[i][rq_cnt[i]] = cmd;
    rq_cnt[i]++;
  endtask

  task automatic exp_gnt(input int i, input logic [15:0] cmd);
    gnt_t g;
    g.idx = i;
    g.cmd = cmd;
    exp_gnt_q.push_back(g);
  endtask

  task automatic exp_rsp(input int i, input logic [7:0] data, input logic err, input logic chk_data);
    rsp_t r;
    r.idx      = i;
    r.data     = data;
    r.err      = err;
    r.chk_data = chk_data;
    exp_rsp_q.push_back(r);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq_cnt[i] - rq_head[i];
    return s;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && !(exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 &&
                           !bus.busy && pending() == 0)) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d grants and %0d responses outstanding, required 0",
               exp_gnt_q.size(), exp_rsp_q.size());
    end
    repeat (2) @(negedge clk);
    #3;
  endtask

  // Requester driver: a command is consumed on the edge after req_ready is seen.
  initial begin
    forever begin
      @(negedge clk);
      drv_acc = bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (rst_n && drv_acc[i] && rq_head[i] < rq_cnt[i]) rq_head[i]++;
        req_v[i]            = (rq_head[i] < rq_cnt[i]);
        req_d[i*CW +: CW]   = req_v[i] ? rq_cmd[i][rq_head[i]] : 16'h0000;
      end
    end
  end

  // Engine: accepts when ready & valid, busy for BUSY cycles, then ready again.
  initial begin
    forever begin
      @(negedge clk);
      eng_rv = 1'b0;
      if (!rst_n) begin
        eng_ready = 1'b1;
        eng_cnt   = 0;
        eng_pend  = 1'b0;
      end else if (eng_pend) begin
        eng_pend  = 1'b0;
        eng_ready = 1'b0;
        eng_cnt   = BUSY;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_is_read && !eng_pfail &&
            ((eng_rv_late && eng_cnt == 0) || (!eng_rv_late && eng_cnt == 1))) begin
          eng_rv = 1'b1;
          eng_rd = eng_rdata;
        end
        if (eng_cnt == 0) eng_ready = 1'b1;
      end else if (eng_ready && bus.uart_cmd_valid) begin
        eng_pend    = 1'b1;
        eng_is_read = !bus.uart_cmd_data[CW-1];
      end
    end
  end

  // Monitor
  logic        prev_gnt       = 1'b0;
  logic        prev_eng_ready = 1'b1;
  logic        rsp_due        = 1'b0;
  logic [15:0] last_cmd       = 16'h0000;

  initial begin
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        prev_gnt       = 1'b0;
        prev_eng_ready = 1'b1;
        rsp_due        = 1'b0;
        continue;
      end
      if (prev_gnt) chk("cmd_valid_after_grant", 32'(bus.uart_cmd_valid), 32'd1);
      if (rsp_due)  chk("rsp_one_cycle_after_ready", 32'(|bus.rsp_valid), 32'd1);
      if (|bus.req_ready) begin
        if (exp_gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got req_ready 0x%0h, required none", bus.req_ready);
        end else begin
          g = exp_gnt_q.pop_front();
          chk("grant", 32'(bus.req_ready), 32'd1 << g.idx);
          last_cmd = g.cmd;
        end
      end
      if (bus.uart_cmd_valid && bus.uart_cmd_ready)
        chk("cmd_data_at_accept", 32'(bus.uart_cmd_data), 32'(last_cmd));
      if (|bus.rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid 0x%0h, required none", bus.rsp_valid);
        end else begin
          r = exp_rsp_q.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << r.idx);
          chk("rsp_owner", 32'(bus.owner), 32'(r.idx));
          chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          if (r.chk_data) chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
        end
      end
      rsp_due        = bus.busy && !prev_eng_ready && bus.uart_cmd_ready;
      prev_eng_ready = bus.uart_cmd_ready;
      prev_gnt       = |bus.req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // All four requesters active out of reset: rotation 0,1,2,3 then 0 again.
    push_req(0, 16'h8100); push_req(1, 16'h8111); push_req(2, 16'h8122);
    push_req(3, 16'h8133); push_req(0, 16'h8105);
    exp_gnt(0, 16'h8100); exp_gnt(1, 16'h8111); exp_gnt(2, 16'h8122);
    exp_gnt(3, 16'h8133); exp_gnt(0, 16'h8105);
    for (int i = 0; i < 4; i++) exp_rsp(i, 8'h00, 1'b0, 1'b1);
    exp_rsp(0, 8'h00, 1'b0, 1'b1);

    repeat (2) @(negedge clk); #3;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_cmd_valid", 32'(bus.uart_cmd_valid), 32'd0);
    chk("reset_cmd_data", 32'(bus.uart_cmd_data), 32'd0);
    chk("reset_owner", 32'(bus.owner), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    drain(1000);

    // Write from req1 (rr_ptr now 1).
    push_req(1, 16'h8A3C);
    exp_gnt(1, 16'h8A3C);
    exp_rsp(1, 8'h00, 1'b0, 1'b1);
    drain(200);

    // Read from req2; data arrives together with engine ready.
    eng_rdata = 8'hA5; eng_pfail = 1'b0; eng_rv_late = 1'b1;
    push_req(2, 16'h1200);
    exp_gnt(2, 16'h1200);
    exp_rsp(2, 8'hA5, 1'b0, 1'b1);
    drain(200);

    // Read from req0 that ends without read_valid.
    eng_pfail = 1'b1;
    push_req(0, 16'h0033);
    exp_gnt(0, 16'h0033);
    exp_rsp(0, 8'h00, 1'b1, 1'b0);
    drain(200);

    // Read from req3; data pulse one cycle before ready.
    eng_pfail = 1'b0; eng_rv_late = 1'b0; eng_rdata = 8'h3C;
    push_req(3, 16'h0042);
    exp_gnt(3, 16'h0042);
    exp_rsp(3, 8'h3C, 1'b0, 1'b1);
    drain(200);

    // req0 and req2 both busy: strict alternation starting at 0.
    push_req(0, 16'h8201); push_req(0, 16'h8203); push_req(0, 16'h8205);
    push_req(2, 16'h8202); push_req(2, 16'h8204); push_req(2, 16'h8206);
    exp_gnt(0, 16'h8201); exp_gnt(2, 16'h8202); exp_gnt(0, 16'h8203);
    exp_gnt(2, 16'h8204); exp_gnt(0, 16'h8205); exp_gnt(2, 16'h8206);
    for (int k = 0; k < 3; k++) begin
      exp_rsp(0, 8'h00, 1'b0, 1'b1);
      exp_rsp(2, 8'h00, 1'b0, 1'b1);
    end
    drain(1000);

    // Abort a write from req1 during WAIT_DONE; no response may follow.
    push_req(1, 16'h8777);
    exp_gnt(1, 16'h8777);
    begin
      int n = 0;
      while (!bus.busy && n < 50) begin
        @(negedge clk); #3;
        n++;
      end
      chk("abort_reached_busy", 32'(bus.busy), 32'd1);
    end
    repeat (3) @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_owner", 32'(bus.owner), 32'd0);
    chk("abort_cmd_data", 32'(bus.uart_cmd_data), 32'd0);
    chk("abort_cmd_valid", 32'(bus.uart_cmd_valid), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    // rr_ptr back at 0, so req1 must win over req3.
    push_req(3, 16'h8399); push_req(1, 16'h8199);
    exp_gnt(1, 16'h8199); exp_gnt(3, 16'h8399);
    exp_rsp(1, 8'h00, 1'b0, 1'b1); exp_rsp(3, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    drain(500);

    chk("grant_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
